// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding, opcodes and frame width for the SPI master controller
package spi_pkg;
  localparam int FRAME_W = 10;
  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;
  typedef enum logic [2:0] {S_IDLE, S_CMD, S_SHIFT, S_WAIT, S_READ, S_GUARD} state_t;
endpackage

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: frames a 10-bit command onto SPI and, for rd-data, collects the returned byte
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int RD_GAP = 2,
  parameter int GUARD  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [FRAME_W-1:0] cmd_frame,
  output logic [7:0]         rd_data,
  output logic               rd_valid,
  output logic               busy,
  output logic               SS_n,
  output logic               MOSI,
  input  logic               MISO
);
  localparam logic [3:0] GAP_T = 4'(RD_GAP - 1);
  localparam logic [3:0] GRD_T = 4'(GUARD - 1);
  state_t             state;
  logic [3:0]         cnt;
  logic [FRAME_W-1:0] sr;
  logic [1:0]         op;
  logic [7:0]         rx;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_GUARD;
      cnt       <= '0;
      SS_n      <= 1'b1;
      MOSI      <= 1'b0;
      busy      <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      cmd_ready <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (cmd_valid) begin
          sr        <= cmd_frame;
          op        <= cmd_frame[9:8];
          state     <= S_CMD;
          SS_n      <= 1'b0;
          MOSI      <= cmd_frame[9];
          busy      <= 1'b1;
          cmd_ready <= 1'b0;
        end
        S_CMD: begin
          state <= S_SHIFT;
          cnt   <= '0;
          MOSI  <= sr[9];
        end
        S_SHIFT: if (cnt == 4'd9) begin
          cnt  <= '0;
          MOSI <= 1'b0;
          if (op == OP_RD_DATA) state <= S_WAIT;
          else begin
            state <= S_GUARD;
            SS_n  <= 1'b1;
          end
        end else begin
          cnt  <= cnt + 4'd1;
          MOSI <= sr[8];
          sr   <= {sr[8:0], 1'b0};
        end
        S_WAIT: if (cnt == GAP_T) begin
          cnt   <= '0;
          state <= S_READ;
        end else cnt <= cnt + 4'd1;
        S_READ: begin
          rx <= {rx[6:0], MISO};
          if (cnt == 4'd7) begin
            cnt      <= '0;
            state    <= S_GUARD;
            SS_n     <= 1'b1;
            rd_valid <= 1'b1;
            rd_data  <= {rx[6:0], MISO};
          end else cnt <= cnt + 4'd1;
        end
        S_GUARD: begin
          rd_valid <= 1'b0;
          if (cnt == GRD_T) begin
            cnt       <= '0;
            state     <= S_IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end else cnt <= cnt + 4'd1;
        end
        default: state <= S_GUARD;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: table, corner-case and random RAM-slave checks of spi_master_ctrl
module tb_spi_master_ctrl;
  localparam int RG = 2;
  localparam int GD = 1;
  logic       clk = 0;
  logic       rst = 1;
  logic       cmd_valid = 0;
  logic       cmd_ready;
  logic [9:0] cmd_frame = '0;
  logic [7:0] rd_data;
  logic       rd_valid, busy, SS_n, MOSI;
  logic       MISO = 0;
  int total = 0;
  int bad = 0;
  logic [7:0] exp_rd;
  logic [7:0] s_ram [256];
  logic [7:0] m_ram [256];
  logic [7:0] s_addr, m_addr;
  typedef struct packed {logic [9:0] f; logic [7:0] m;} vec_t;
  vec_t tv [7];

  spi_master_ctrl #(.RD_GAP(RG), .GUARD(GD)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_frame(cmd_frame), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", n, a, e, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic guard_release();
    chk("rel_ready0", cmd_ready, 0);
    for (int j = 1; j <= GD; j++) begin
      step();
      chk("rel_ready", cmd_ready, j == GD);
      chk("rel_ss", SS_n, 1);
    end
  endtask

  task automatic do_frame(input logic [9:0] f, input logic [7:0] mb, input bit use_ram,
                          input bit hold, input logic [9:0] nxt, input logic [7:0] ex,
                          output int waited);
    int w, kend, r0;
    logic rd, e_mosi;
    logic [9:0] obs;
    logic [7:0] b;
    w = 0;
    while (!cmd_ready && w < 64) begin
      step();
      w++;
    end
    waited = w;
    if (!cmd_ready) begin
      chk("ready_timeout", cmd_ready, 1);
      return;
    end
    cmd_valid = 1;
    cmd_frame = f;
    rd = (f[9:8] == 2'b11);
    b = mb;
    obs = '0;
    r0 = 12 + RG;
    kend = rd ? 20 + RG : 12;
    for (int k = 1; k <= kend + GD; k++) begin
      step();
      cmd_valid = hold;
      cmd_frame = hold ? nxt : 10'($urandom);
      e_mosi = (k == 1) ? f[9] : (k <= 11 ? f[11-k] : 1'b0);
      if (rd && k == kend) exp_rd = ex;
      chk("ss_n", SS_n, k < kend ? 0 : 1);
      chk("mosi", MOSI, e_mosi);
      chk("rd_valid", rd_valid, rd && k == kend);
      chk("busy", busy, k < kend + GD);
      chk("cmd_ready", cmd_ready, k == kend + GD);
      chk("rd_data", rd_data, exp_rd);
      if (k >= 2 && k <= 11) obs[11-k] = MOSI;
      if (k == 11 && use_ram)
        case (obs[9:8])
          2'b00, 2'b10: s_addr = obs[7:0];
          2'b01: s_ram[s_addr] = obs[7:0];
          default: b = s_ram[s_addr];
        endcase
      MISO = (rd && k >= r0 && k < r0 + 8) ? b[7-(k-r0)] : 1'($urandom);
    end
  endtask

  task automatic host_op(input logic [1:0] op, input logic [7:0] p);
    logic [7:0] ex;
    int w;
    ex = 8'h00;
    case (op)
      2'b00, 2'b10: m_addr = p;
      2'b01: m_ram[m_addr] = p;
      default: ex = m_ram[m_addr];
    endcase
    do_frame({op, p}, 8'h00, 1, 0, 10'h0, ex, w);
  endtask

  initial begin
    int w;
    for (int i = 0; i < 256; i++) begin
      s_ram[i] = 8'($urandom);
      m_ram[i] = s_ram[i];
    end
    s_addr = 0;
    m_addr = 0;
    tv[0] = {10'b00_0000_0101, 8'h00};
    tv[1] = {10'b11_0000_0000, 8'hA5};
    tv[2] = {10'b11_1111_1111, 8'h00};
    tv[3] = {10'b01_1111_1111, 8'h00};
    tv[4] = {10'b10_1010_1010, 8'h00};
    tv[5] = {10'b11_0101_1010, 8'hFF};
    tv[6] = {10'b11_1000_0001, 8'h01};

    repeat (3) step();
    chk("rst_ss", SS_n, 1);
    chk("rst_mosi", MOSI, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_ready", cmd_ready, 0);
    rst = 0;
    exp_rd = 8'h00;
    guard_release();

    cmd_valid = 1;
    cmd_frame = 10'h300;
    for (int k = 1; k <= 15; k++) begin
      step();
      cmd_valid = 0;
      MISO = 1'($urandom);
    end
    rst = 1;
    step();
    chk("abort_ss", SS_n, 1);
    chk("abort_mosi", MOSI, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", cmd_ready, 0);
    for (int j = 0; j < 8; j++) begin
      chk("abort_rd_valid", rd_valid, 0);
      chk("abort_rd_data", rd_data, 0);
      if (j == 2) rst = 0;
      if (j < 7) step();
    end
    while (!cmd_ready) step();

    cmd_valid = 1;
    cmd_frame = 10'h305;
    rst = 1;
    step();
    cmd_valid = 0;
    chk("rst_prio_ss", SS_n, 1);
    chk("rst_prio_busy", busy, 0);
    chk("rst_prio_ready", cmd_ready, 0);
    rst = 0;
    guard_release();

    for (int i = 0; i < 7; i++) do_frame(tv[i].f, tv[i].m, 0, 0, 10'h0, tv[i].m, w);

    do_frame(10'b01_1100_0011, 8'h00, 0, 1, 10'b11_0011_1100, 8'h00, w);
    do_frame(10'b11_0011_1100, 8'h96, 0, 0, 10'h0, 8'h96, w);
    chk("b2b_wait", w, 0);
    cmd_valid = 0;

    host_op(2'b00, 8'h3C);
    host_op(2'b01, 8'h5A);
    host_op(2'b10, 8'h3C);
    host_op(2'b11, 8'h00);
    chk("e2e_rd_data", rd_data, 8'h5A);

    for (int i = 0; i < 40; i++) begin
      logic [1:0] op;
      op = 2'($urandom_range(0, 3));
      host_op(op, op[0] ? 8'($urandom) : 8'($urandom_range(0, 7)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
